ram_dp_pipe: RTL and testbench

RAM_DP_PIPE -- requirements
Module: ram_dp_pipe

---
 rtl/ram_dp_pipe.sv | 112 +++++++++++
 tb/tb_ram_dp_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_pipe.sv
// Simple dual-port RAM (one write, one read port) with byte-lane write enables and a
// RD_LATENCY-deep registered read pipeline. Optional per-byte parity: RAM_DP_PIPE_PARITY_EN.
module ram_dp_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic                    err_inject,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic                    collision,
    output logic                    parity_err
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] stage_data [RD_LATENCY];
    logic [RD_LATENCY-1:0] stage_valid;

    // Memory array has no reset so contents survive rstn.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 samples mem before the same-edge write lands, giving read-first behaviour.
    // Data registers only load with a valid read so data_out holds between pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_valid <= '0;
            collision   <= 1'b0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage_data[i] <= '0;
            end
        end else begin
            collision      <= wr_en & rd_en & (wr_addr == rd_addr);
            stage_valid[0] <= rd_en;
            if (rd_en) begin
                stage_data[0] <= mem[rd_addr];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                if (stage_valid[i-1]) begin
                    stage_data[i] <= stage_data[i-1];
                end
            end
        end
    end

    assign data_out  = stage_data[RD_LATENCY-1];
    assign valid_out = stage_valid[RD_LATENCY-1];

`ifdef RAM_DP_PIPE_PARITY_EN
    logic [NUM_BYTES-1:0]  par_mem [DEPTH];
    logic [NUM_BYTES-1:0]  rd_par_calc;
    logic                  rd_perr;
    logic [RD_LATENCY-1:0] stage_perr;

    // Stored bit makes each byte even; err_inject flips it for the lanes being written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_be[b]) begin
                    par_mem[wr_addr][b] <= (^wr_data[8*b +: 8]) ^ err_inject;
                end
            end
        end
    end

    always_comb begin
        rd_par_calc = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            rd_par_calc[b] = ^mem[rd_addr][8*b +: 8];
        end
    end

    assign rd_perr = |(rd_par_calc ^ par_mem[rd_addr]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_perr <= '0;
        end else begin
            stage_perr[0] <= rd_en & rd_perr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage_perr[i] <= stage_valid[i-1] & stage_perr[i-1];
            end
        end
    end

    assign parity_err = stage_perr[RD_LATENCY-1];
`else
    logic unused_err_inject;
    assign unused_err_inject = err_inject;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_dp_pipe.sv
// Scoreboard bench for ram_dp_pipe: the driver queues expected read results with their
// due cycle, a negedge monitor pops and compares on every valid_out pulse.
module tb_ram_dp_pipe;

    localparam int LAT = 2;
`ifdef RAM_DP_PIPE_PARITY_EN
    localparam logic PAR_EXP = 1'b1;
`else
    localparam logic PAR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic        err_inject = 1'b0;
    logic [31:0] data_out;
    logic        valid_out;
    logic        collision;
    logic        parity_err;

    ram_dp_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .err_inject(err_inject),
        .data_out(data_out), .valid_out(valid_out), .collision(collision),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        perr;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          n_pulse = 0;
    logic [31:0] last_exp = '0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (valid_out) begin
                exp_t e;
                n_pulse++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got data %h with nothing queued (cycle %0d)",
                             data_out, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rd_data", data_out, e.data);
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_parity_err", {31'b0, parity_err}, {31'b0, e.perr});
                    last_exp = e.data;
                end
            end else begin
                chk("data_hold", data_out, last_exp);
                chk("parity_idle", {31'b0, parity_err}, 32'd0);
            end
        end
    end

    task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic inj, input logic re,
                        input logic [3:0] ra, input logic [31:0] ed, input logic ep);
        exp_t e;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; err_inject = inj;
        rd_en = re; rd_addr = ra;
        if (re) begin
            e.data = ed; e.perr = ep; e.cyc = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic inj);
        step(1'b1, a, d, be, inj, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] ed, input logic ep);
        step(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 1'b1, a, ed, ep);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_out"}, data_out, 32'd0);
        chk({tag, "_valid_out"}, {31'b0, valid_out}, 32'd0);
        chk({tag, "_collision"}, {31'b0, collision}, 32'd0);
        chk({tag, "_parity_err"}, {31'b0, parity_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses_before;

        repeat (3) @(negedge clk);
        #1 chk_reset_outputs("reset");
        @(posedge clk); #2 rstn = 1'b1;

        // First edge after release writes; basic latency read.
        wr(4'd3, 32'hDEADBEEF, 4'hF, 1'b0);
        rd(4'd3, 32'hDEADBEEF, 1'b0);
        idle(3);

        // Byte-lane merge and wr_be=0 write nothing.
        wr(4'd5, 32'h11223344, 4'hF, 1'b0);
        wr(4'd5, 32'hAABBCCDD, 4'h5, 1'b0);
        rd(4'd5, 32'h11BB33DD, 1'b0);
        wr(4'd3, 32'hFFFFFFFF, 4'h0, 1'b0);
        rd(4'd3, 32'hDEADBEEF, 1'b0);
        idle(3);

        // Same-address collision: read-first, one-cycle registered pulse.
        wr(4'd7, 32'h12345678, 4'hF, 1'b0);
        step(1'b1, 4'd7, 32'h00000000, 4'hF, 1'b0, 1'b1, 4'd7, 32'h12345678, 1'b0);
        idle(1);
        #1 chk("collision_pulse", {31'b0, collision}, 32'd1);
        idle(1);
        #1 chk("collision_clear", {31'b0, collision}, 32'd0);
        rd(4'd7, 32'h00000000, 1'b0);
        idle(3);

        // Different-address read and write in one cycle do not interact.
        step(1'b1, 4'd8, 32'h55AA55AA, 4'hF, 1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
        idle(1);
        #1 chk("no_collision", {31'b0, collision}, 32'd0);
        rd(4'd8, 32'h55AA55AA, 1'b0);
        idle(3);

        // Back-to-back burst.
        wr(4'd0, 32'hA0A0A0A0, 4'hF, 1'b0);
        wr(4'd1, 32'hB1B1B1B1, 4'hF, 1'b0);
        wr(4'd2, 32'hC2C2C2C2, 4'hF, 1'b0);
        rd(4'd0, 32'hA0A0A0A0, 1'b0);
        rd(4'd1, 32'hB1B1B1B1, 1'b0);
        rd(4'd2, 32'hC2C2C2C2, 1'b0);
        rd(4'd3, 32'hDEADBEEF, 1'b0);
        idle(4);

        // Burst cut by reset after two pulses; the rest must be dropped.
        pulses_before = n_pulse;
        rd(4'd0, 32'hA0A0A0A0, 1'b0);
        rd(4'd1, 32'hB1B1B1B1, 1'b0);
        rd(4'd2, 32'hC2C2C2C2, 1'b0);
        rd(4'd3, 32'hDEADBEEF, 1'b0);
        @(posedge clk); #2;
        rstn = 1'b0;
        rd_en = 1'b0;
        sb.delete();
        last_exp = '0;
        #1 chk_reset_outputs("midburst_reset");
        @(posedge clk); #2 rstn = 1'b1;
        rd(4'd5, 32'h11BB33DD, 1'b0);
        idle(6);
        chk("pulses_across_reset", n_pulse - pulses_before, 32'd3);

        // Parity injection, then a clean rewrite clears it.
        wr(4'd9, 32'hCAFEF00D, 4'hF, 1'b1);
        rd(4'd9, 32'hCAFEF00D, PAR_EXP);
        wr(4'd9, 32'hCAFEF00D, 4'hF, 1'b0);
        rd(4'd9, 32'hCAFEF00D, 1'b0);
        idle(5);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
